phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Free-list allocator for the physical register file.
//  - Hands out unused physical register tags to the rename stage, up to ALLOC_W per cycle.
//  - Reclaims tags released at retire, up to FREE_W per cycle.
//  - Tags 0 and 1 are the hardwired constant registers (0x00, 0x01). They are never stored, granted or reclaimed.
//  - Storage is a circular FIFO of DEPTH = NUM_PREGS-2 tag entries with explicit head/tail wrap.
// PARAMETERS
//  NUM_PREGS  32  total physical tags including constants 0 and 1
//  TAG_W       5  tag width; must satisfy 2**TAG_W >= NUM_PREGS
//  ALLOC_W     2  allocation lanes per cycle
//  FREE_W      6  release lanes per cycle; matches register-file write ports
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              asynchronous, active-high reset
//  alloc_req   in   ALLOC_W        lane i requests one tag; any bit pattern is legal
//  alloc_ready out  1              1 when free_count >= ALLOC_W
//  alloc_tags  out  ALLOC_W*TAG_W  lane i tag, valid when alloc_ready & alloc_req[i]
//  free_valid  in   FREE_W         lane i releases free_tags[i]
//  free_tags   in   FREE_W*TAG_W   released tags
//  free_count  out  $clog2(NUM_PREGS-1)  number of tags currently held in the list
//  err         out  1              sticky misuse flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate even mid-operation):
//   - entry[k] = k+2 for k = 0..DEPTH-1; head = 0; tail = 0; count = DEPTH.
//   - Outputs: free_count = DEPTH; alloc_ready = 1; err = 0.
//   - After reset, alloc_tags shows entry[head..] (2,3,...).
//  Allocation:
//   - alloc_ready depends on count only. It never depends on alloc_req, so there is no comb loop with rename.
//   - fire = alloc_ready & |alloc_req. Grant is all-or-nothing.
//   - Lane i tag = entry[(head + popcount(alloc_req[i-1:0])) mod DEPTH]. Tags are compacted, combinational, 0-cycle latency.
//   - On fire, head += popcount(alloc_req) mod DEPTH at posedge.
//   - When alloc_ready = 0, requests are ignored and head holds. The requester re-presents next cycle.
//  Release:
//   - A lane counts only if free_valid[i] & free_tags[i] >= 2. Lanes with tag 0/1 are silently dropped.
//   - Counted lanes are written in ascending lane order, compacted, at tail, tail+1, ... mod DEPTH.
//   - Tail advances by the number of counted lanes.
//  Count:
//   - count_next = count - granted + written.
//   - No bypass: a tag freed in cycle N is grantable no earlier than cycle N+1.
//   - Grants in cycle N use only entries present at the start of cycle N.
//  Overflow:
//   - Releases that would push count above DEPTH are dropped from the highest lane down.
//   - Legal use never overflows; a dropped release sets err (see CONFIGURATION).
//  Wrap-around:
//   - DEPTH is not a power of two, so pointers wrap by compare-and-subtract, never by truncation.
//  Simultaneous alloc + release with count = ALLOC_W:
//   - The grant proceeds from existing entries.
//   - The released tags are appended, and count returns to ALLOC_W.
//  No state machine: all state is entry[], head, tail, count and err.
// CONFIGURATION
//  Macro FREELIST_CHECK_EN selects misuse checking.
//  Defined:
//   - Keep a NUM_PREGS-bit in_list bitmap.
//   - A release of a tag already in the list (double free) is dropped and sets err.
//   - Overflow also sets err.
//   - err is sticky until rst.
//  Not defined:
//   - No bitmap; double frees are stored as normal.
//   - Overflow is still dropped; err is tied to 0.
// STRUCTURE
//  Shared package ooo_pkg:
//   - PREG_TAG_W, NUM_PREGS, PREG_ZERO = 0, PREG_ONE = 1, FREELIST_DEPTH = NUM_PREGS-2.
//   - These are shared with the register file and the rename table.
//  Sub-module:
//   - Single module; the ring and pointer logic stays inline.
//   - One natural sub-module: popcount_prefix (prefix popcount of a lane mask), shared by the alloc and release compaction.
// TESTING
//  1. Reset; alloc_req = 2'b11 -> alloc_tags = {3,2}; next cycle free_count = 28, tags show {5,4}.
//  2. Alloc 2/cycle for 15 cycles -> free_count = 0, alloc_ready = 0; hold alloc_req = 2'b11 -> head and count unchanged.
//  3. Release lanes {tag 7, tag 0, tag 1} in one cycle -> only 7 is appended, count +1; 7 is granted after the remaining earlier entries.
//  4. Drain all 30, release 31..2 over 5 cycles, re-allocate -> returned order 31,30,...,2 across the index 29->0 wrap.
//  5. count = 2, alloc 2'b11 plus release {9,10} in the same cycle -> granted tags are the old entries; count stays 2; 9,10 are granted next.
//  6. FREELIST_CHECK_EN: after reset, release tag 5 -> err = 1 and stays 1, count unchanged. Without the macro, err = 0 throughout.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants: physical tag geometry and the two hardwired constant registers.
// Used by the register file, the rename table and the free list.
package ooo_pkg;

    localparam int PREG_TAG_W     = 5;
    localparam int NUM_PREGS      = 32;
    localparam int PREG_ZERO      = 0;
    localparam int PREG_ONE       = 1;
    localparam int FREELIST_DEPTH = NUM_PREGS - 2;

    typedef logic [PREG_TAG_W-1:0] preg_tag_t;

endpackage

// File: rtl/popcount_prefix.sv
// Exclusive prefix popcount of a lane mask: prefix[i] = number of set bits in mask[i-1:0].
// Shared by the alloc and release compaction in the free list.
module popcount_prefix #(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         mask,
    output logic [W-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int unsigned i = 0; i < W; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(mask[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: circular FIFO of tags 2..NUM_PREGS-1, multi-lane alloc and release.
// Define FREELIST_CHECK_EN to enable the in-list bitmap with double-free detection and a sticky err.
module phys_reg_free_list #(
    parameter int NUM_PREGS = ooo_pkg::NUM_PREGS,
    parameter int TAG_W     = ooo_pkg::PREG_TAG_W,
    parameter int ALLOC_W   = 2,
    parameter int FREE_W    = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ALLOC_W-1:0]             alloc_req,
    output logic                           alloc_ready,
    output logic [ALLOC_W*TAG_W-1:0]       alloc_tags,
    input  logic [FREE_W-1:0]              free_valid,
    input  logic [FREE_W*TAG_W-1:0]        free_tags,
    output logic [$clog2(NUM_PREGS-1)-1:0] free_count,
    output logic                           err
);

    import ooo_pkg::*;

    localparam int unsigned DEPTH = NUM_PREGS - 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_PREGS - 1);
    localparam int AW = $clog2(ALLOC_W + 1);
    localparam int FW = $clog2(FREE_W + 1);

    logic [TAG_W-1:0] entry [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic [ALLOC_W-1:0][AW-1:0] alloc_pre;
    logic [AW-1:0]              alloc_total;
    logic [FREE_W-1:0]          rel_elig;
    logic [FREE_W-1:0][FW-1:0]  rel_pre;
    logic [FW-1:0]              rel_total;
    logic [FREE_W-1:0]          rel_take;
    logic                       fire;
    logic [AW-1:0]              granted;
    logic [FW-1:0]              written;
    int unsigned                space;

`ifdef FREELIST_CHECK_EN
    logic [NUM_PREGS-1:0] in_list;
    logic [FREE_W-1:0]    dup;
    logic                 overflow;
    logic                 err_q;
`endif

    // DEPTH need not be a power of two, so wrap by compare-and-subtract.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    popcount_prefix #(.W(ALLOC_W), .CW(AW)) u_alloc_pc (
        .mask   (alloc_req),
        .prefix (alloc_pre),
        .total  (alloc_total)
    );

    popcount_prefix #(.W(FREE_W), .CW(FW)) u_rel_pc (
        .mask   (rel_elig),
        .prefix (rel_pre),
        .total  (rel_total)
    );

    assign alloc_ready = (count >= CW'(ALLOC_W));
    assign free_count  = count;

    always_comb begin
        alloc_tags = '0;
        for (int unsigned i = 0; i < ALLOC_W; i++)
            alloc_tags[i*TAG_W +: TAG_W] = entry[ptr_add(head, 32'(alloc_pre[i]))];
    end

    always_comb begin
        rel_elig = '0;
`ifdef FREELIST_CHECK_EN
        dup = '0;
`endif
        for (int unsigned i = 0; i < FREE_W; i++) begin
            rel_elig[i] = free_valid[i] && (free_tags[i*TAG_W +: TAG_W] > TAG_W'(PREG_ONE));
`ifdef FREELIST_CHECK_EN
            // A tag already listed, or repeated on a lower lane this cycle, is a double free.
            if (rel_elig[i]) begin
                if (in_list[free_tags[i*TAG_W +: TAG_W]]) dup[i] = 1'b1;
                for (int unsigned j = 0; j < i; j++)
                    if (rel_elig[j] && (free_tags[j*TAG_W +: TAG_W] == free_tags[i*TAG_W +: TAG_W]))
                        dup[i] = 1'b1;
            end
            rel_elig[i] = rel_elig[i] && !dup[i];
`endif
        end
    end

    // Slots available this cycle include those vacated by the current grant; excess lanes drop high-first.
    always_comb begin
        fire     = alloc_ready && (|alloc_req);
        granted  = fire ? alloc_total : '0;
        space    = DEPTH - 32'(count) + 32'(granted);
        rel_take = '0;
        for (int unsigned i = 0; i < FREE_W; i++)
            rel_take[i] = rel_elig[i] && (32'(rel_pre[i]) < space);
        written  = (32'(rel_total) > space) ? FW'(space) : rel_total;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++)
                entry[k] <= TAG_W'(k + 2);
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
        end else begin
            for (int unsigned i = 0; i < FREE_W; i++)
                if (rel_take[i])
                    entry[ptr_add(tail, 32'(rel_pre[i]))] <= free_tags[i*TAG_W +: TAG_W];
            if (fire) head <= ptr_add(head, 32'(alloc_total));
            tail  <= ptr_add(tail, 32'(written));
            count <= CW'(32'(count) - 32'(granted) + 32'(written));
        end
    end

`ifdef FREELIST_CHECK_EN
    assign overflow = (32'(rel_total) > space);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_list <= {{(NUM_PREGS-2){1'b1}}, 2'b00};
            err_q   <= 1'b0;
        end else begin
            if (fire)
                for (int unsigned i = 0; i < ALLOC_W; i++)
                    if (alloc_req[i]) in_list[alloc_tags[i*TAG_W +: TAG_W]] <= 1'b0;
            for (int unsigned i = 0; i < FREE_W; i++)
                if (rel_take[i]) in_list[free_tags[i*TAG_W +: TAG_W]] <= 1'b1;
            if (overflow || (|dup)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: per-cycle vector table plus hand sequences for reset,
// double free and async reset. Expectations for err/double free follow FREELIST_CHECK_EN.
module tb_phys_reg_free_list;

    localparam int TAG_W   = 5;
    localparam int ALLOC_W = 2;
    localparam int FREE_W  = 6;
`ifdef FREELIST_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [ALLOC_W-1:0]       alloc_req;
    logic                     alloc_ready;
    logic [ALLOC_W*TAG_W-1:0] alloc_tags;
    logic [FREE_W-1:0]        free_valid;
    logic [FREE_W*TAG_W-1:0]  free_tags;
    logic [4:0]               free_count;
    logic                     err;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0]  req;
        logic [5:0]  fv;
        logic [29:0] ft;
        logic [1:0]  tmask;
        int          t0;
        int          t1;
        int          rdy;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    phys_reg_free_list #(
        .NUM_PREGS (32),
        .TAG_W     (TAG_W),
        .ALLOC_W   (ALLOC_W),
        .FREE_W    (FREE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_ready (alloc_ready),
        .alloc_tags  (alloc_tags),
        .free_valid  (free_valid),
        .free_tags   (free_tags),
        .free_count  (free_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [29:0] ft6(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
        return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic add(input logic [1:0] req, input logic [5:0] fv, input logic [29:0] ft,
                       input logic [1:0] tmask, input int t0, input int t1, input int rdy, input int cnt);
        vec_t v;
        v.req = req; v.fv = fv; v.ft = ft; v.tmask = tmask;
        v.t0 = t0; v.t1 = t1; v.rdy = rdy; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int lane_tag(input int lane);
        logic [ALLOC_W*TAG_W-1:0] t;
        t = alloc_tags;
        return int'(t[lane*TAG_W +: TAG_W]);
    endfunction

    initial begin
        // Phase 1: 14 double grants from reset, 2..29 in order.
        for (int k = 0; k < 14; k++)
            add(2'b11, 6'b0, 30'd0, 2'b11, 2 + 2*k, 3 + 2*k, 1, 30 - 2*k);
        // Phase 3: release {7,0,1}; 7 follows the remaining 30,31.
        add(2'b00, 6'b000111, ft6(7, 0, 1, 0, 0, 0), 2'b00, 0, 0, 1, 2);
        add(2'b11, 6'b0, 30'd0, 2'b11, 30, 31, 1, 3);
        add(2'b11, 6'b0, 30'd0, 2'b00, 0, 0, 0, 1);
        add(2'b00, 6'b100000, ft6(0, 0, 0, 0, 0, 8), 2'b00, 0, 0, 0, 1);
        add(2'b11, 6'b0, 30'd0, 2'b11, 7, 8, 1, 2);
        add(2'b11, 6'b0, 30'd0, 2'b00, 0, 0, 0, 0);
        add(2'b11, 6'b0, 30'd0, 2'b00, 0, 0, 0, 0);
        // Phase 4: release 31..2 across the ring wrap, then drain in that order.
        for (int c = 0; c < 5; c++)
            add(2'b00, 6'b111111, ft6(31-6*c, 30-6*c, 29-6*c, 28-6*c, 27-6*c, 26-6*c),
                2'b00, 0, 0, (6*c >= 2) ? 1 : 0, 6*c);
        for (int k = 0; k < 15; k++)
            add(2'b11, 6'b0, 30'd0, 2'b11, 31 - 2*k, 30 - 2*k, 1, 30 - 2*k);
        // Phase 5: grant and release in one cycle at count = 2.
        add(2'b00, 6'b000011, ft6(20, 21, 0, 0, 0, 0), 2'b00, 0, 0, 0, 0);
        add(2'b11, 6'b000011, ft6(9, 10, 0, 0, 0, 0), 2'b11, 20, 21, 1, 2);
        add(2'b11, 6'b0, 30'd0, 2'b11, 9, 10, 1, 2);
        // Phase 6: refill to full.
        for (int c = 0; c < 5; c++)
            add(2'b00, 6'b111111, ft6(2+6*c, 3+6*c, 4+6*c, 5+6*c, 6+6*c, 7+6*c),
                2'b00, 0, 0, (6*c >= 2) ? 1 : 0, 6*c);
        add(2'b00, 6'b0, 30'd0, 2'b01, 2, 0, 1, 30);

        rst = 1'b1; alloc_req = '0; free_valid = '0; free_tags = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        alloc_req = 2'b11;
        #1;
        chk("reset_count", int'(free_count), 30);
        chk("reset_ready", int'(alloc_ready), 1);
        chk("reset_err", int'(err), 0);
        chk("reset_tag0", lane_tag(0), 2);
        chk("reset_tag1", lane_tag(1), 3);
        alloc_req = 2'b00;

        foreach (vecs[n]) begin
            @(negedge clk);
            alloc_req  = vecs[n].req;
            free_valid = vecs[n].fv;
            free_tags  = vecs[n].ft;
            #1;
            chk($sformatf("v%0d_count", n), int'(free_count), vecs[n].cnt);
            chk($sformatf("v%0d_ready", n), int'(alloc_ready), vecs[n].rdy);
            chk($sformatf("v%0d_err", n), int'(err), 0);
            if (vecs[n].tmask[0]) chk($sformatf("v%0d_tag0", n), lane_tag(0), vecs[n].t0);
            if (vecs[n].tmask[1]) chk($sformatf("v%0d_tag1", n), lane_tag(1), vecs[n].t1);
        end

        // Release of a listed tag while full: dropped either way, err only with checking.
        @(negedge clk);
        alloc_req = 2'b00; free_valid = 6'b000001; free_tags = ft6(5, 0, 0, 0, 0, 0);
        #1 chk("full_count", int'(free_count), 30);
        @(negedge clk);
        free_valid = '0; free_tags = '0;
        #1;
        chk("dfree_count", int'(free_count), 30);
        chk("dfree_err", int'(err), CHK);
        @(negedge clk);
        #1 chk("err_sticky", int'(err), CHK);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        alloc_req = 2'b11;
        @(negedge clk);
        alloc_req = 2'b00;
        #1 chk("pre_rst_count", int'(free_count), 28);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(free_count), 30);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_ready", int'(alloc_ready), 1);

        // Sparse request patterns compact onto the head.
        @(negedge clk);
        rst = 1'b0; alloc_req = 2'b10;
        #1;
        chk("req10_tag1", lane_tag(1), 2);
        chk("req10_count", int'(free_count), 30);
        @(negedge clk);
        alloc_req = 2'b01;
        #1;
        chk("req01_tag0", lane_tag(0), 3);
        chk("req01_count", int'(free_count), 29);
        @(negedge clk);
        alloc_req = 2'b11;
        #1;
        chk("req11_tag0", lane_tag(0), 4);
        chk("req11_tag1", lane_tag(1), 5);
        chk("req11_count", int'(free_count), 28);

        // Double free of tag 9 while not full: stored without checking, dropped with it.
        @(negedge clk);
        alloc_req = 2'b00; free_valid = 6'b000100; free_tags = ft6(0, 0, 9, 0, 0, 0);
        #1 chk("dfree2_pre_count", int'(free_count), 26);
        @(negedge clk);
        free_valid = '0; free_tags = '0;
        #1;
        chk("dfree2_count", int'(free_count), (CHK != 0) ? 26 : 27);
        chk("dfree2_err", int'(err), CHK);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
